// File: rtl/decode_rf.sv
// Decode stage with integrated register file for the RV32I/RV32E core.
// Optional macro DECODE_BYPASS_EN enables write-through forwarding from the write-back port.
module decode_rf #(
  parameter int          NREG     = 32,
  parameter logic [31:0] NOP_INST = 32'h00000013,
  parameter logic [31:0] PC_RESET = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] I_PC,
  input  logic        I_VALID,
  input  logic [31:0] I_INST,
  input  logic        W_VALID,
  input  logic [4:0]  W_RD,
  input  logic [31:0] W_DATA,
  output logic [31:0] D_PC,
  output logic        D_VALID,
  output logic [6:0]  D_OPCODE,
  output logic [2:0]  D_FUNCT3,
  output logic [6:0]  D_FUNCT7,
  output logic [31:0] D_IMM,
  output logic [4:0]  D_REG_D,
  output logic [4:0]  D_REG_S1,
  output logic [31:0] D_REG_S1_V,
  output logic [4:0]  D_REG_S2,
  output logic [31:0] D_REG_S2_V,
  output logic        D_ILLEGAL
);

  localparam logic [5:0] NREG_L = 6'(NREG);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] inst_q;
  logic [31:0] rf [32];
  logic        wr_en;
  logic        op_known;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q    <= PC_RESET;
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
    end else if (FLUSH) begin
      pc_q    <= PC_RESET;
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
    end else if (!STALL) begin
      pc_q    <= I_PC;
      valid_q <= I_VALID;
      inst_q  <= I_INST;
    end
  end

  // Entries at or above NREG are never written, so they stay zero and get trimmed.
  assign wr_en = W_VALID && (W_RD != 5'd0) && ({1'b0, W_RD} < NREG_L);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (wr_en) begin
      rf[W_RD] <= W_DATA;
    end
  end

  assign D_PC     = pc_q;
  assign D_VALID  = valid_q;
  assign D_OPCODE = inst_q[6:0];
  assign D_FUNCT3 = inst_q[14:12];
  assign D_FUNCT7 = inst_q[31:25];
  assign D_REG_D  = inst_q[11:7];
  assign D_REG_S1 = inst_q[19:15];
  assign D_REG_S2 = inst_q[24:20];

  always_comb begin
    D_IMM    = '0;
    op_known = 1'b1;
    case (inst_q[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_FENCE:
        D_IMM = {{20{inst_q[31]}}, inst_q[31:20]};
      OP_STORE:
        D_IMM = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
      OP_BRANCH:
        D_IMM = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        D_IMM = {inst_q[31:12], 12'b0};
      OP_JAL:
        D_IMM = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
      OP_REG:
        D_IMM = '0;
      default: begin
        D_IMM    = '0;
        op_known = 1'b0;
      end
    endcase
  end

  // The register-field check is format-agnostic; for NREG=32 it is always false.
  assign D_ILLEGAL = valid_q && (!op_known ||
                                 ({1'b0, D_REG_D}  >= NREG_L) ||
                                 ({1'b0, D_REG_S1} >= NREG_L) ||
                                 ({1'b0, D_REG_S2} >= NREG_L));

  always_comb begin
    D_REG_S1_V = '0;
    D_REG_S2_V = '0;
    if ((D_REG_S1 != 5'd0) && ({1'b0, D_REG_S1} < NREG_L)) begin
      D_REG_S1_V = rf[D_REG_S1];
`ifdef DECODE_BYPASS_EN
      if (wr_en && (W_RD == D_REG_S1)) D_REG_S1_V = W_DATA;
`endif
    end
    if ((D_REG_S2 != 5'd0) && ({1'b0, D_REG_S2} < NREG_L)) begin
      D_REG_S2_V = rf[D_REG_S2];
`ifdef DECODE_BYPASS_EN
      if (wr_en && (W_RD == D_REG_S2)) D_REG_S2_V = W_DATA;
`endif
    end
  end

endmodule
